line_prefetch: RTL
==================

LINE_PREFETCH -- requirements
Module: line_prefetch

Interface
REQ-001 Parameter DEPTH, default 16, gives the FIFO depth in 16-bit words; it SHALL be a power of two, at least 4.
REQ-002 Parameter ADDR_W, default 26, gives the width of the bridge byte address.
REQ-003 clk  in  1  the single clock; all logic SHALL be rising-edge synchronous to clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to fetch a line.
REQ-006 base_addr  in  ADDR_W  byte address of the first word; bit 0 SHALL be ignored and treated as 0.
REQ-007 word_count  in  11  number of 16-bit words to fetch (0..2047).
REQ-008 busy  out  1  high while a fetch is in progress.
REQ-009 done  out  1  one-cycle pulse when a fetch completes.
REQ-010 avalon_bridge_address  out  ADDR_W  byte address of the current read.
REQ-011 avalon_bridge_byte_enable  out  2  tied to 2'b11.
REQ-012 avalon_bridge_read  out  1  read request.
REQ-013 avalon_bridge_write  out  1  tied to 0.
REQ-014 avalon_bridge_write_data  out  16  tied to 0.
REQ-015 avalon_bridge_acknowledge  in  1  read completion strobe.
REQ-016 avalon_bridge_read_data  in  16  read data, valid in the acknowledge cycle.
REQ-017 pop  in  1  consumer dequeue strobe.
REQ-018 q  out  16  FIFO head word, first-word-fall-through.
REQ-019 empty  out  1  FIFO empty flag.
REQ-020 level  out  log2(DEPTH)+1  FIFO occupancy in words.

Function
REQ-021 The FSM SHALL have three states: IDLE, REQ and STALL.
REQ-022 In IDLE, start with word_count>0 SHALL latch base_addr and word_count and move to REQ if level<DEPTH, otherwise to STALL; busy SHALL rise in the next cycle.
REQ-023 In IDLE, start with word_count=0 SHALL pulse done in the next cycle, issue no read, and leave busy low.
REQ-024 start SHALL be ignored while busy is high.
REQ-025 In REQ, avalon_bridge_read SHALL be high and avalon_bridge_address SHALL hold steady until the cycle in which avalon_bridge_acknowledge is sampled high.
REQ-026 At most one read SHALL be outstanding at any time.
REQ-027 In an acknowledge cycle, read_data SHALL be pushed into the FIFO.
REQ-028 In an acknowledge cycle, the address SHALL increment by 2, with modulo 2^ADDR_W wrap-around.
REQ-029 In an acknowledge cycle, the remaining count SHALL decrement by 1.
REQ-030 In the cycle after an acknowledge, read SHALL be low (minimum one idle cycle between requests).
REQ-031 After an acknowledge with the remaining count reaching 0, the block SHALL go to IDLE, pulse done for exactly one cycle, and drop busy in that same cycle.
REQ-032 After an acknowledge with a nonzero remaining count, the block SHALL go to REQ if the post-push level<DEPTH, otherwise to STALL.
REQ-033 STALL SHALL hold read low and move to REQ in the cycle after level<DEPTH is seen.
REQ-034 A new read SHALL never be issued when level=DEPTH, so the FIFO never overflows and no acknowledged data is dropped.
REQ-035 An acknowledge received while read is low SHALL be ignored.
REQ-036 The FIFO SHALL use a circular buffer with wrapping read and write pointers.
REQ-037 q SHALL equal the oldest stored word whenever empty=0.
REQ-038 pop while empty=1 SHALL be ignored.
REQ-039 A simultaneous push and pop SHALL leave level unchanged and keep the FIFO in order.
REQ-040 A simultaneous push and pop when level=DEPTH is not possible because of REQ-034.
REQ-041 level and empty SHALL update in the cycle after a push or pop.
REQ-042 The FIFO contents SHALL persist across fetches; a new start SHALL NOT flush the FIFO.

Reset
REQ-043 While reset is high, the block SHALL be in IDLE with busy=0, done=0 and avalon_bridge_read=0.
REQ-044 While reset is high, avalon_bridge_address=0, level=0, empty=1 and q=0.
REQ-045 Reset asserted mid-fetch SHALL drop read in the next cycle, abandon the remaining words, and empty the FIFO.
REQ-046 An acknowledge arriving during or after reset SHALL be ignored until a new start.

Verification
REQ-047 Scenario: start, base_addr=0x0001000, word_count=4, acknowledge 2 cycles after each read, no pops -> reads at 0x1000, 0x1002, 0x1004 and 0x1006; level reaches 4; one done pulse; busy low afterward.
REQ-048 Scenario: DEPTH=16, word_count=20, no pops -> exactly 16 reads, then the block holds STALL with read low. Popping 4 words at 1 per cycle -> 4 further reads; FIFO data equals the bridge data in order.
REQ-049 Scenario: word_count=0 -> done pulses 1 cycle after start; read never asserts; busy stays 0.
REQ-050 Scenario: base_addr=0x3FFFFFE, word_count=2 -> reads at 0x3FFFFFE, then 0x0000000.
REQ-051 Scenario: pop every cycle while acknowledges arrive every 2nd cycle -> level never exceeds 1; pops on empty are ignored; q order matches the read order.
REQ-052 Scenario: reset asserted while read is high on the 3rd word, then an acknowledge arrives 1 cycle later -> read drops; level=0; empty=1; no push; done never pulses.

Source files
------------

// File: rtl/line_prefetch.sv
// Line prefetcher: reads a run of 16-bit words over an Avalon bridge, one read in
// flight at a time, into a first-word-fall-through FIFO drained by the consumer.
module line_prefetch #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 26
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic [10:0]            word_count,
   output logic                   busy,
   output logic                   done,
   output logic [ADDR_W-1:0]      avalon_bridge_address,
   output logic [1:0]             avalon_bridge_byte_enable,
   output logic                   avalon_bridge_read,
   output logic                   avalon_bridge_write,
   output logic [15:0]            avalon_bridge_write_data,
   input  logic                   avalon_bridge_acknowledge,
   input  logic [15:0]            avalon_bridge_read_data,
   input  logic                   pop,
   output logic [15:0]            q,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, STALL} state_t;

   state_t          state;
   logic [10:0]     remaining;
   logic [15:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push_c;
   logic            pop_c;
   logic [LW-1:0]   level_next_c;

   assign avalon_bridge_byte_enable = 2'b11;
   assign avalon_bridge_write       = 1'b0;
   assign avalon_bridge_write_data  = 16'h0000;

   // An acknowledge only counts while our read is actually asserted.
   assign push_c = avalon_bridge_read && avalon_bridge_acknowledge;
   assign pop_c  = pop && !empty;

   always_comb begin
      level_next_c = level + LW'(push_c) - LW'(pop_c);
   end

   // Fetch control; read drops after every acknowledge to leave an idle gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                 <= IDLE;
         busy                  <= 1'b0;
         done                  <= 1'b0;
         avalon_bridge_read    <= 1'b0;
         avalon_bridge_address <= '0;
         remaining             <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (word_count != 11'd0) begin
                     avalon_bridge_address <= base_addr & ~(ADDR_W'(1));
                     remaining             <= word_count;
                     busy                  <= 1'b1;
                     if (level < FULL) begin
                        state              <= REQ;
                        avalon_bridge_read <= 1'b1;
                     end else begin
                        state <= STALL;
                     end
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (push_c) begin
                  avalon_bridge_read    <= 1'b0;
                  avalon_bridge_address <= avalon_bridge_address + ADDR_W'(2);
                  remaining             <= remaining - 11'd1;
                  if (remaining == 11'd1) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (level_next_c < FULL) begin
                     state <= REQ;
                  end else begin
                     state <= STALL;
                  end
               end else if (!avalon_bridge_read) begin
                  avalon_bridge_read <= 1'b1;
               end
            end
            STALL: begin
               if (level < FULL) begin
                  state              <= REQ;
                  avalon_bridge_read <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Circular buffer pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         empty  <= 1'b1;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         level <= level_next_c;
         empty <= (level_next_c == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c && !reset) mem[wr_ptr] <= avalon_bridge_read_data;
   end

   assign q = empty ? 16'h0000 : mem[rd_ptr];

endmodule
